// File: rtl/kmp_pkg.sv
// rtl/kmp_pkg.sv - shared widths and FSM state encoding for the KMP table builder and matcher
package kmp_pkg;

  localparam int CHAR_W  = 8;
  localparam int MAX_PAT = 8;
  localparam int ADDR_W  = $clog2(MAX_PAT);
  localparam int LEN_W   = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    STEP,
    DONE
  } state_e;

endpackage

// File: rtl/kmp_prefix_table_comparator.sv
// rtl/kmp_prefix_table_comparator.sv - CHAR_W-wide character equality comparator
module kmp_prefix_table_comparator #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/kmp_prefix_table.sv
// rtl/kmp_prefix_table.sv - builds the KMP failure table from a pattern held in a synchronous ROM
module kmp_prefix_table #(
  parameter  int CHAR_W  = kmp_pkg::CHAR_W,
  parameter  int MAX_PAT = kmp_pkg::MAX_PAT,
  localparam int ADDR_W  = $clog2(MAX_PAT),
  localparam int LEN_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pat_len,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [CHAR_W-1:0] pat_data,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [LEN_W-1:0]  tbl_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import kmp_pkg::*;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  plen_q, plen_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              err_q, err_d;
  logic [CHAR_W-1:0] pat_buf_q [MAX_PAT];
  logic [CHAR_W-1:0] pat_buf_d [MAX_PAT];
  // lps values never exceed MAX_PAT-1, so ADDR_W bits hold every table entry
  logic [ADDR_W-1:0] lps_q [MAX_PAT];
  logic [ADDR_W-1:0] lps_d [MAX_PAT];

  logic              chr_eq;
  logic [LEN_W-1:0]  last_idx;
  logic              at_last;
  logic [ADDR_W-1:0] len_inc;

  assign last_idx = plen_q - LEN_W'(1);
  assign at_last  = ({1'b0, i_q} == last_idx);
  assign len_inc  = len_q + ADDR_W'(1);

  kmp_prefix_table_comparator #(
    .W(CHAR_W)
  ) u_cmp (
    .a (pat_buf_q[i_q]),
    .b (pat_buf_q[len_q]),
    .eq(chr_eq)
  );

  // Next-state, datapath updates and outputs; one KMP decision per STEP cycle
  always_comb begin
    state_d   = state_q;
    plen_d    = plen_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    len_d     = len_q;
    err_d     = err_q;
    pat_buf_d = pat_buf_q;
    lps_d     = lps_q;
    pat_addr  = '0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_data  = '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    err       = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          plen_d = pat_len;
          cnt_d  = '0;
          i_d    = '0;
          len_d  = '0;
          if (pat_len == '0 || pat_len > LEN_W'(MAX_PAT)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        // Address leads data by one cycle, so slot cnt-1 is captured while cnt is driven
        if (cnt_q < plen_q) begin
          pat_addr = cnt_q[ADDR_W-1:0];
        end
        if (cnt_q != '0) begin
          pat_buf_d[ADDR_W'(cnt_q - LEN_W'(1))] = pat_data;
        end
        if (cnt_q == plen_q) begin
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end

      INIT: begin
        tbl_we   = 1'b1;
        lps_d[0] = '0;
        i_d      = ADDR_W'(1);
        len_d    = '0;
        state_d  = (plen_q == LEN_W'(1)) ? DONE : STEP;
      end

      STEP: begin
        if (chr_eq) begin
          tbl_we       = 1'b1;
          tbl_addr     = i_q;
          tbl_data     = {1'b0, len_inc};
          lps_d[i_q]   = len_inc;
          len_d        = len_inc;
          i_d          = i_q + ADDR_W'(1);
          if (at_last) state_d = DONE;
        end else if (len_q != '0) begin
          // Fallback cycle: shrink the candidate border, no table write
          len_d = lps_q[len_q - ADDR_W'(1)];
        end else begin
          tbl_we     = 1'b1;
          tbl_addr   = i_q;
          tbl_data   = '0;
          lps_d[i_q] = '0;
          i_d        = i_q + ADDR_W'(1);
          if (at_last) state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the buffers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      plen_q  <= '0;
      cnt_q   <= '0;
      i_q     <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < MAX_PAT; k++) begin
        pat_buf_q[k] <= '0;
        lps_q[k]     <= '0;
      end
    end else begin
      state_q   <= state_d;
      plen_q    <= plen_d;
      cnt_q     <= cnt_d;
      i_q       <= i_d;
      len_q     <= len_d;
      err_q     <= err_d;
      pat_buf_q <= pat_buf_d;
      lps_q     <= lps_d;
    end
  end

endmodule

// File: tb/tb_kmp_prefix_table.sv
// tb/tb_kmp_prefix_table.sv - self-checking bench for kmp_prefix_table
module tb_kmp_prefix_table;

  localparam int CW = 8;
  localparam int MP = 8;
  localparam int AW = 3;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] pat_len;
  logic [AW-1:0] pat_addr;
  logic [CW-1:0] pat_data;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [LW-1:0] tbl_data;
  logic          busy;
  logic          done;
  logic          err;

  logic [7:0] rom [8];

  int checks = 0;
  int errors = 0;

  int w_addr[$];
  int w_data[$];
  int n_done;
  int n_busy;
  bit t_out;
  logic err_at_end;

  typedef struct {
    logic [63:0] pat;
    int          plen;
    logic [31:0] lps;
    int          steps;
    bit          err;
  } vec_t;

  vec_t vecs[11];

  kmp_prefix_table #(
    .CHAR_W (CW),
    .MAX_PAT(MP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pat_len (pat_len),
    .pat_addr(pat_addr),
    .pat_data(pat_data),
    .tbl_we  (tbl_we),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous pattern ROM: data one cycle after address
  always @(posedge clk) pat_data <= rom[pat_addr];

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] s2p(input string s);
    logic [63:0] r = '0;
    for (int k = 0; k < s.len() && k < 8; k++) r[8*k +: 8] = s[k];
    return r;
  endfunction

  function automatic logic [31:0] d2n(input string s);
    logic [31:0] r = '0;
    for (int k = 0; k < s.len() && k < 8; k++) r[4*k +: 4] = 4'(s[k] - 8'd48);
    return r;
  endfunction

  // Reference: longest proper border of each prefix by direct string comparison
  function automatic logic [31:0] ref_lps(input logic [63:0] p, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) begin
      int best = 0;
      for (int l = 1; l <= k; l++) begin
        bit ok = 1'b1;
        for (int j = 0; j < l; j++)
          if (p[8*j +: 8] != p[8*(k-l+1+j) +: 8]) ok = 1'b0;
        if (ok) best = l;
      end
      r[4*k +: 4] = 4'(best);
    end
    return r;
  endfunction

  task automatic load_rom(input logic [63:0] p);
    for (int k = 0; k < 8; k++) rom[k] = p[8*k +: 8];
  endtask

  task automatic run_pat(input int plen, input bit spam);
    w_addr.delete();
    w_data.delete();
    n_done = 0;
    n_busy = 0;
    t_out  = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    pat_len = 4'(plen);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (tbl_we) begin
        w_addr.push_back(int'(tbl_addr));
        w_data.push_back(int'(tbl_data));
      end
      if (done) n_done++;
      if (busy) n_busy++;
      if (spam && busy && !done) begin
        start   = 1'($urandom % 2);
        pat_len = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (!busy) break;
      if (c == 79) t_out = 1'b1;
    end
    err_at_end = err;
  endtask

  task automatic verify(input string tag, input int plen, input bit exp_err, input logic [31:0] exp_lps);
    int n = exp_err ? 0 : plen;
    chk({tag, " timeout"}, int'(t_out), 0);
    chk({tag, " writes"}, w_addr.size(), n);
    for (int k = 0; k < w_addr.size() && k < n; k++) begin
      chk($sformatf("%s addr%0d", tag, k), w_addr[k], k);
      chk($sformatf("%s lps%0d", tag, k), w_data[k], int'(exp_lps[4*k +: 4]));
    end
    chk({tag, " done"}, n_done, 1);
    chk({tag, " err"}, int'(err_at_end), int'(exp_err));
    if (exp_err) chk({tag, " busy"}, n_busy, 1);
  endtask

  initial begin
    logic [63:0] rp;
    int          rl;
    int          st;
    bit          seen;

    rst     = 1'b0;
    start   = 1'b0;
    pat_len = '0;
    load_rom(s2p("ABAB"));
    repeat (2) @(negedge clk);
    chk("reset outputs", int'({busy, done, err, tbl_we, tbl_addr, tbl_data, pat_addr}), 0);
    rst = 1'b1;

    vecs[0]  = '{s2p("ABAB"),     4,  d2n("0012"),     3, 1'b0};
    vecs[1]  = '{s2p("AAAA"),     4,  d2n("0123"),     3, 1'b0};
    vecs[2]  = '{s2p("AABAAAB"),  7,  d2n("0101223"),  8, 1'b0};
    vecs[3]  = '{s2p("A"),        1,  d2n("0"),        0, 1'b0};
    vecs[4]  = '{s2p("ABCDEFGH"), 8,  d2n("00000000"), 7, 1'b0};
    vecs[5]  = '{s2p("AAAAAAAA"), 8,  d2n("01234567"), 7, 1'b0};
    vecs[6]  = '{s2p("ABAB"),     2,  d2n("00"),       1, 1'b0};
    vecs[7]  = '{s2p("ABACABAB"), 8,  d2n("00101232"), 9, 1'b0};
    vecs[8]  = '{s2p("ABAB"),     0,  32'h0,           0, 1'b1};
    vecs[9]  = '{s2p("ABAB"),     9,  32'h0,           0, 1'b1};
    vecs[10] = '{s2p("ABAB"),     15, 32'h0,           0, 1'b1};

    for (int v = 0; v < 11; v++) begin
      load_rom(vecs[v].pat);
      run_pat(vecs[v].plen, 1'b0);
      verify($sformatf("vec%0d", v), vecs[v].plen, vecs[v].err, vecs[v].lps);
      if (!vecs[v].err)
        chk($sformatf("vec%0d steps", v), n_busy - vecs[v].plen - 3, vecs[v].steps);
    end

    // randomized patterns over a small alphabet to provoke fallbacks
    for (int r = 0; r < 30; r++) begin
      rp = '0;
      rl = int'($urandom_range(1, 8));
      for (int k = 0; k < rl; k++) rp[8*k +: 8] = 8'd65 + 8'($urandom % 3);
      for (int k = rl; k < 8; k++) rp[8*k +: 8] = 8'($urandom);
      load_rom(rp);
      run_pat(rl, 1'b0);
      verify($sformatf("rand%0d", r), rl, 1'b0, ref_lps(rp, rl));
      st = n_busy - rl - 3;
      chk($sformatf("rand%0d steps lo", r), int'(st >= rl - 1), 1);
      if (rl >= 2) chk($sformatf("rand%0d steps hi", r), int'(st <= 2 * rl - 3), 1);
    end

    // reset asserted during STEP of ABCD
    load_rom(s2p("ABCD"));
    @(negedge clk);
    start   = 1'b1;
    pat_len = 4'd4;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (tbl_we) seen = 1'b1;
    end
    chk("abort init seen", int'(seen), 1);
    @(negedge clk);
    chk("abort in step", int'({tbl_we, tbl_addr}), int'({1'b1, 3'd1}));
    #1 rst = 1'b0;
    #1 chk("abort outputs", int'({busy, done, err, tbl_we, tbl_addr, tbl_data, pat_addr}), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort held", int'({busy, tbl_we}), 0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort no restart", int'({busy, tbl_we}), 0);
    end
    run_pat(4, 1'b0);
    verify("restart", 4, 1'b0, d2n("0000"));
    chk("restart steps", n_busy - 4 - 3, 3);

    // start and pat_len toggled while busy
    load_rom(s2p("ABAB"));
    run_pat(4, 1'b1);
    verify("spam", 4, 1'b0, d2n("0012"));
    repeat (3) begin
      @(negedge clk);
      chk("spam idle", int'({busy, tbl_we}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
